// File: rtl/vga_timing_gen.sv
// Raster timing: h/v counters advanced by pix_en, active-high syncs, de, coordinates, line/frame markers.
// Optional build macro VGA_TIMING_OUTREG_EN registers every output (+1 clk, loads every clk).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CW < 1 || H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_params
      $error("vga_timing_gen: zero-width region or total exceeds counter range");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYN_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYN_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYN_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYN_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;

  // v_cnt only moves on the edge where h_cnt wraps, keeping vsync line-aligned.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic          hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
  logic [CW-1:0] x_d, y_d;

  always_comb begin
    hsync_d       = 1'b0;
    vsync_d       = 1'b0;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    x_d           = '0;
    y_d           = '0;
    if (!rst) begin
      hsync_d       = (h_cnt_q >= H_SYN_BEG) && (h_cnt_q < H_SYN_END);
      vsync_d       = (v_cnt_q >= V_SYN_BEG) && (v_cnt_q < V_SYN_END);
      de_d          = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
    end
  end

`ifdef VGA_TIMING_OUTREG_EN
  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [CW-1:0] x_q, y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign x           = x_q;
  assign y           = y_q;
`else
  assign hsync       = hsync_d;
  assign vsync       = vsync_d;
  assign de          = de_d;
  assign line_start  = line_start_d;
  assign frame_start = frame_start_d;
  assign x           = x_d;
  assign y           = y_d;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small (8x6) and default (800x525) instances checked against a pixel-index reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  always #5 clk = ~clk;

  logic        hs_s, vs_s, de_s, ls_s, fs_s;
  logic [11:0] x_s, y_s;
  logic        hs_d, vs_d, de_d, ls_d, fs_d;
  logic [11:0] x_d, y_d;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CW(12)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  out_t obs_s, obs_d;
  assign obs_s = {hs_s, vs_s, de_s, ls_s, fs_s, x_s, y_s};
  assign obs_d = {hs_d, vs_d, de_d, ls_d, fs_d, x_d, y_d};

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_s    = 0;  // pixel strobes seen since the last reset
  int   n_d    = 0;
  out_t prev_s, prev_d;
  bit   prev_vld = 1'b0;

  // Reference: position in the raster derived from the count of pixel strobes.
  function automatic out_t ref_out(input int ha, hf, hs, hb, va, vf, vs, vb,
                                   input int n, input bit r);
    out_t o;
    int ht, vt, h, v;
    o = '0;
    if (r) return o;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    o.hs = (h >= ha + hf) && (h < ha + hf + hs);
    o.vs = (v >= va + vf) && (v < va + vf + vs);
    o.de = (h < ha) && (v < va);
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    o.x  = 12'(h);
    o.y  = 12'(v);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic compare(input string nm, input out_t o, input out_t e);
    chk({nm, ".hsync"},       32'(o.hs), 32'(e.hs));
    chk({nm, ".vsync"},       32'(o.vs), 32'(e.vs));
    chk({nm, ".de"},          32'(o.de), 32'(e.de));
    chk({nm, ".line_start"},  32'(o.ls), 32'(e.ls));
    chk({nm, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    chk({nm, ".x"},           32'(o.x),  32'(e.x));
    chk({nm, ".y"},           32'(o.y),  32'(e.y));
  endtask

  // One clk: drive inputs after the falling edge, check mid-cycle, then advance the model.
  task automatic cycle(input bit r, input bit p);
    out_t es, ed;
    rst    = r;
    pix_en = p;
    #1;
    es = ref_out(4, 1, 2, 1, 3, 1, 1, 1, n_s, r);
    ed = ref_out(640, 16, 96, 48, 480, 10, 2, 33, n_d, r);
    if (prev_vld) begin
`ifdef VGA_TIMING_OUTREG_EN
      compare("small", obs_s, prev_s);
      compare("dflt",  obs_d, prev_d);
`else
      compare("small", obs_s, es);
      compare("dflt",  obs_d, ed);
`endif
    end
    prev_s   = es;
    prev_d   = ed;
    prev_vld = 1'b1;
    @(posedge clk);
    if (r) begin
      n_s = 0;
      n_d = 0;
    end else if (p) begin
      n_s++;
      n_d++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    @(negedge clk);

    repeat (3) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b1);

    // Free-running: two full small frames plus change.
    repeat (110) cycle(1'b0, 1'b1);

    // Strobe every other clk; outputs must hold through the idle clks.
    for (int i = 0; i < 60; i++) cycle(1'b0, (i % 2) == 0);

    // Random strobes with occasional reset.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1);

    // Walk to h=5, v=4 in the small raster, then pulse reset for one clk.
    for (int i = 0; i < 48 && (n_s % 48) != 37; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);

    // Hold strobes at the last pixel of the small frame, then wrap.
    for (int i = 0; i < 48 && (n_s % 48) != 47; i++) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);

    // Fresh start and a long run covering two full default-size lines.
    cycle(1'b1, 1'b0);
    repeat (1700) cycle(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
